systolic_drain: RTL and testbench

SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

---
 rtl/systolic_drain_if.sv | 27 ++
 rtl/systolic_drain.sv | 87 ++++++++
 tb/tb_systolic_drain.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_drain_if.sv
// Handshake bundle between the systolic array bottom row, the drain buffer
// and the downstream element consumer.
interface systolic_drain_if #(
    parameter int N = 4
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic          cap_valid;
    logic [23:0]   row_in [N];
    logic          cap_ready;
    logic          out_valid;
    logic [23:0]   out_data;
    logic          out_ready;
    logic [CW-1:0] out_col;
    logic          out_last;
    logic          overflow;

    modport master (
        output cap_valid, row_in, out_ready,
        input  cap_ready, out_valid, out_data, out_col, out_last, overflow
    );

    modport slave (
        input  cap_valid, row_in, out_ready,
        output cap_ready, out_valid, out_data, out_col, out_last, overflow
    );
endinterface

// File: rtl/systolic_drain.sv
// Row FIFO that captures bottom-row psums of a systolic array and
// serializes them one element per cycle, column-major within each row.
module systolic_drain #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    systolic_drain_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = AW + 1;
    localparam logic [KW-1:0] FULL  = KW'(DEPTH);
    localparam logic [CW-1:0] LASTC = CW'(N - 1);

    logic [23:0]   r_mem [DEPTH][N];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [KW-1:0] r_count;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic          r_ovf;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_drop;
    logic w_xfer;
    logic w_pop;
    logic w_valid;

    assign w_full  = (r_count == FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.cap_valid && !w_full;
    assign w_drop  = bus.cap_valid && w_full;
    assign w_xfer  = !w_empty && bus.out_ready;
    assign w_pop   = w_xfer && (r_col == LASTC);

    // Storage is never reset; only pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.row_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_xfer) begin
                r_col <= (r_col == LASTC) ? '0 : r_col + 1'b1;
            end
            if (w_pop) begin
                r_row <= (r_row == LASTC) ? '0 : r_row + 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Outputs are forced idle while rst is held, before state clears.
    assign w_valid       = !rst && !w_empty;
    assign bus.cap_ready = rst || !w_full;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? r_mem[r_rptr][r_col] : '0;
    assign bus.out_col   = rst ? '0 : r_col;
    assign bus.out_last  = w_valid && (r_row == LASTC) && (r_col == LASTC);
    assign bus.overflow  = !rst && r_ovf;
endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench: stimulus queues expected elements, a negedge monitor
// pops and compares every transfer and checks hold-on-stall.
module tb_systolic_drain;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [23:0] d;
        logic [1:0]  c;
        logic        l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_drain_if #(.N(N)) bus ();

    systolic_drain #(.N(N), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    exp_t e;
    int   nvec = 0;
    int   nerr = 0;
    int   exp_row = 0;

    logic        ps = 1'b0;
    logic [23:0] pd;
    logic [1:0]  pc;
    logic        pl;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] c, input logic [23:0] d,
                         input bit acc);
        logic [23:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int k = 0; k < N; k++) bus.row_in[k] = v[k];
        bus.cap_valid = 1'b1;
        if (acc) begin
            for (int k = 0; k < N; k++) begin
                e.d = v[k];
                e.c = 2'(k);
                e.l = (exp_row == N - 1) && (k == N - 1);
                q.push_back(e);
            end
            exp_row = (exp_row + 1) % N;
        end
    endtask

    task automatic wait_drain(input string nm, input int want);
        int cyc = 0;
        while (q.size() != 0 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk(nm, cyc, want);
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, "_valid"}, bus.out_valid, 0);
        chk({nm, "_data"}, bus.out_data, 0);
        chk({nm, "_col"}, bus.out_col, 0);
        chk({nm, "_last"}, bus.out_last, 0);
        chk({nm, "_ovf"}, bus.overflow, 0);
        chk({nm, "_capr"}, bus.cap_ready, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cap_valid = 1'b0;
        bus.out_ready = 1'b0;
        q.delete();
        exp_row = 0;
        @(negedge clk);
        idle_chk("rst_during");
        tick();
        rst = 1'b0;
        @(negedge clk);
        idle_chk("rst_after");
        tick();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            ps = 1'b0;
        end else begin
            if (ps) begin
                chk("hold_data", bus.out_data, pd);
                chk("hold_col", bus.out_col, pc);
                chk("hold_last", bus.out_last, pl);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL spurious: got %0h want none", bus.out_data);
                end else begin
                    e = q.pop_front();
                    chk("data", bus.out_data, e.d);
                    chk("col", bus.out_col, e.c);
                    chk("last", bus.out_last, e.l);
                end
            end else if (!bus.out_valid) begin
                chk("idle_data", bus.out_data, 0);
                chk("idle_last", bus.out_last, 0);
            end
            ps = bus.out_valid && !bus.out_ready;
            pd = bus.out_data;
            pc = bus.out_col;
            pl = bus.out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int xf;
        bus.cap_valid = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < N; k++) bus.row_in[k] = '0;

        // single row, latency and order
        do_reset();
        bus.out_ready = 1'b1;
        offer(24'h10, 24'h20, 24'h30, 24'h40, 1);
        tick();
        bus.cap_valid = 1'b0;
        @(negedge clk);
        chk("lat_valid", bus.out_valid, 1);
        chk("lat_col", bus.out_col, 0);
        chk("lat_data", bus.out_data, 24'h10);
        #1;
        wait_drain("single_cycles", 3);

        // four rows back to back, 16 contiguous elements
        do_reset();
        bus.out_ready = 1'b1;
        offer(24'h000101, 24'h000102, 24'h000103, 24'h000104, 1);
        tick();
        offer(24'h000201, 24'h000202, 24'h000203, 24'h000204, 1);
        tick();
        offer(24'h000301, 24'h000302, 24'h000303, 24'h000304, 1);
        tick();
        offer(24'h000401, 24'h000402, 24'h000403, 24'h000404, 1);
        tick();
        bus.cap_valid = 1'b0;
        wait_drain("matrix_cycles", 13);

        // overflow: five rows offered with consumer stalled
        do_reset();
        for (int i = 0; i < 5; i++) begin
            offer(24'h100000 + 24'(i * 16), 24'h200000 + 24'(i * 16),
                  24'h300000 + 24'(i * 16), 24'h400000 + 24'(i * 16),
                  i < 4);
            @(negedge clk);
            chk("fill_capr", bus.cap_ready, (i < 4) ? 1 : 0);
            tick();
        end
        bus.cap_valid = 1'b0;
        @(negedge clk);
        chk("ovf_set", bus.overflow, 1);
        chk("full_capr", bus.cap_ready, 0);
        tick();
        bus.out_ready = 1'b1;
        wait_drain("ovf_drain_cycles", 16);
        chk("ovf_sticky", bus.overflow, 1);

        // full buffer with toggling consumer
        do_reset();
        offer(24'h0A0001, 24'h0A0002, 24'h0A0003, 24'h0A0004, 1);
        tick();
        offer(24'h0B0001, 24'h0B0002, 24'h0B0003, 24'h0B0004, 1);
        tick();
        offer(24'h0C0001, 24'h0C0002, 24'h0C0003, 24'h0C0004, 1);
        tick();
        offer(24'h0D0001, 24'h0D0002, 24'h0D0003, 24'h0D0004, 1);
        tick();
        bus.cap_valid = 1'b0;
        xf = 0;
        for (int j = 0; j < 8; j++) begin
            bus.out_ready = (j % 2 == 0);
            @(negedge clk);
            chk("toggle_capr", bus.cap_ready, (xf >= 4) ? 1 : 0);
            tick();
            if (bus.out_ready) xf++;
        end
        bus.out_ready = 1'b1;
        wait_drain("toggle_drain_cycles", 12);

        // reset mid-matrix, with capture and ready also asserted
        do_reset();
        bus.out_ready = 1'b1;
        offer(24'h111111, 24'h222222, 24'h333333, 24'h444444, 1);
        tick();
        offer(24'h555555, 24'h666666, 24'h777777, 24'h888888, 1);
        tick();
        bus.cap_valid = 1'b0;
        repeat (5) tick();
        chk("pre_rst_left", q.size(), 2);
        q.delete();
        rst = 1'b1;
        offer(24'hDEAD01, 24'hDEAD02, 24'hDEAD03, 24'hDEAD04, 0);
        @(negedge clk);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_capr", bus.cap_ready, 1);
        tick();
        rst = 1'b0;
        bus.cap_valid = 1'b0;
        exp_row = 0;
        @(negedge clk);
        chk("post_rst_valid", bus.out_valid, 0);
        chk("post_rst_ovf", bus.overflow, 0);
        chk("post_rst_capr", bus.cap_ready, 1);
        tick();
        offer(24'h00C0DE, 24'h01C0DE, 24'h02C0DE, 24'h03C0DE, 1);
        tick();
        bus.cap_valid = 1'b0;
        @(negedge clk);
        chk("restart_col", bus.out_col, 0);
        chk("restart_data", bus.out_data, 24'h00C0DE);
        #1;
        wait_drain("restart_cycles", 3);

        // maximum value passes untouched
        do_reset();
        bus.out_ready = 1'b1;
        offer(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1);
        tick();
        bus.cap_valid = 1'b0;
        wait_drain("max_cycles", 4);
        tick();
        chk("end_empty", bus.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
